// File: rtl/riscv_pkg.sv
// Shared constants for the single-cycle RV32 core.
//
// Contents:
//   XLEN              - address/data width in bits
//   RESET_VECTOR      - default value loaded into the program counter on reset
//   INSTR_ALIGN_BITS  - number of low PC bits that must be zero for an
//                       aligned 32-bit instruction fetch
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    localparam int INSTR_ALIGN_BITS = 2;

endpackage

// File: rtl/dff_rstn.sv
// Generic W-bit register with a synchronous, active-low reset.
//
// Parameters:
//   W     - register width
//   INIT  - value loaded when reset is sampled low
// Ports:
//   clk   in   1   clock, rising-edge triggered
//   rst   in   1   synchronous reset, active-low (0 = reset)
//   d     in   W   data loaded on every non-reset rising edge
//   q     out  W   registered value
module dff_rstn #(
    parameter int             W    = 1,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    // Reset is only looked at on the clock edge; there is no enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= INIT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_reg.sv
// Program-counter register of the single-cycle RV32 core.
// Holds the fetch address and loads the next-PC value on every rising edge.
//
// Parameters:
//   XLEN          - address width in bits
//   RESET_VECTOR  - value loaded into PC on reset
// Ports:
//   clk          in   1     system clock
//   rst          in   1     synchronous reset, active-low (0 = reset)
//   NPC          in   XLEN  next program counter from the next-PC mux
//   PC           out  XLEN  current program counter (registered)
//   pc_misalign  out  1     only with PC_ALIGN_EN: NPC loaded on the last
//                           edge had non-zero low bits
//
// Build option:
//   PC_ALIGN_EN - when defined, the low INSTR_ALIGN_BITS of NPC are forced
//                 to zero on load and pc_misalign reports whether they were
//                 set. When undefined, NPC is loaded verbatim and the
//                 pc_misalign port does not exist.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int              XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  NPC,
    output logic [XLEN-1:0]  PC
`ifdef PC_ALIGN_EN
    ,
    output logic             pc_misalign
`endif
);

    logic [XLEN-1:0] load_value;

`ifdef PC_ALIGN_EN
    logic misalign_next;

    // The flag is recomputed every cycle from the incoming NPC, so it is
    // never sticky: a following aligned load clears it.
    assign load_value    = {NPC[XLEN-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
    assign misalign_next = |NPC[INSTR_ALIGN_BITS-1:0];

    dff_rstn #(
        .W    (1),
        .INIT (1'b0)
    ) u_misalign (
        .clk (clk),
        .rst (rst),
        .d   (misalign_next),
        .q   (pc_misalign)
    );
`else
    assign load_value = NPC;
`endif

    dff_rstn #(
        .W    (XLEN),
        .INIT (RESET_VECTOR)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .d   (load_value),
        .q   (PC)
    );

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed sequence followed by randomized
// loads and resets, compared against a behavioural model of the PC.
module tb_pc_reg;

    logic        clk;
    logic        rst;
    logic [31:0] NPC;
    logic [31:0] PC;
`ifdef PC_ALIGN_EN
    logic        pc_misalign;
`endif

    int errorCount = 0;
    int checkCount = 0;

    // Behavioural model state: what PC (and the flag) should read now.
    logic [31:0] expectedPc;
    logic        expectedMis;
    bit          modelValid = 1'b0;

    pc_reg dut (
        .clk (clk),
        .rst (rst),
        .NPC (NPC),
        .PC  (PC)
`ifdef PC_ALIGN_EN
        ,
        .pc_misalign (pc_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: observed=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge, confirm PC has not moved before the
    // rising edge, then advance the model and compare just after the edge.
    task automatic applyStimulus(input logic rstValue, input logic [31:0] npcValue,
                                 input string tag);
        @(negedge clk);
        rst = rstValue;
        NPC = npcValue;
        #2;
        if (modelValid) begin
            checkOutput({tag, "_hold"}, PC, expectedPc);
        end
        @(posedge clk);
        #1;
        if (!rstValue) begin
            expectedPc  = 32'h0000_0000;
            expectedMis = 1'b0;
            modelValid  = 1'b1;
        end else begin
`ifdef PC_ALIGN_EN
            expectedPc  = npcValue - (npcValue % 4);
            expectedMis = (npcValue % 4) != 0;
`else
            expectedPc  = npcValue;
            expectedMis = 1'b0;
`endif
        end
        if (modelValid) begin
            checkOutput(tag, PC, expectedPc);
            checkOutput({tag, "_noX"}, {31'b0, $isunknown(PC)}, 32'd0);
`ifdef PC_ALIGN_EN
            checkOutput({tag, "_mis"}, {31'b0, pc_misalign}, {31'b0, expectedMis});
`endif
        end
    endtask

    initial begin
        logic        rndRst;
        logic [31:0] rndNpc;

        rst = 1'b0;
        NPC = 32'h0;

        $display("[TB] reset");
        applyStimulus(1'b0, 32'h0000_0000, "reset1");
        applyStimulus(1'b0, 32'h0000_0000, "reset2");

        $display("[TB] sequential loads");
        applyStimulus(1'b1, 32'h0000_0004, "load4");
        applyStimulus(1'b1, 32'h0000_0008, "load8");
        applyStimulus(1'b1, 32'h0000_000C, "loadC");
        applyStimulus(1'b1, 32'hFFFF_FFFC, "large");
        applyStimulus(1'b1, 32'hFFFF_FFFC, "same");

        $display("[TB] mid-operation reset");
        applyStimulus(1'b1, 32'h1234_5678, "preReset");
        applyStimulus(1'b0, 32'h1234_5678, "midReset");
        applyStimulus(1'b1, 32'h0000_0000, "release0");
        applyStimulus(1'b1, 32'h0000_0010, "release10");

`ifdef PC_ALIGN_EN
        $display("[TB] alignment");
        applyStimulus(1'b1, 32'h0000_0006, "align6");
        applyStimulus(1'b1, 32'h0000_0008, "align8");
`endif

        $display("[TB] random");
        for (int i = 0; i < 300; i++) begin
            rndRst = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0:       rndNpc = $urandom & 32'hFFFF_FFFC;
                1:       rndNpc = expectedPc + 32'd4;
                2:       rndNpc = $urandom;
                default: rndNpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            endcase
            applyStimulus(rndRst, rndNpc, "random");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
